// File: rtl/cv32e40x_obi_req_stage_if.sv
// ---------------------------------------------------------------------------
// cv32e40x_obi_req_stage_if
// Compressed OBI bus between a master-side request stage and the bus/slave.
//   req          master -> slave  A-channel request (s_req)
//   req_payload  master -> slave  packed address/we/be/wdata
//   gnt          slave  -> master A-channel grant (s_gnt)
//   rvalid       slave  -> master R-channel valid (s_rvalid)
//   resp_payload slave  -> master packed rdata/err
// ---------------------------------------------------------------------------
interface cv32e40x_obi_req_stage_if #(
  parameter int REQ_W  = 32,
  parameter int RESP_W = 33
);
  logic              req;
  logic [REQ_W-1:0]  req_payload;
  logic              gnt;
  logic              rvalid;
  logic [RESP_W-1:0] resp_payload;

  modport master (
    output req,
    output req_payload,
    input  gnt,
    input  rvalid,
    input  resp_payload
  );

  modport slave (
    input  req,
    input  req_payload,
    output gnt,
    output rvalid,
    output resp_payload
  );
endinterface

// File: rtl/cv32e40x_obi_req_stage.sv
// ---------------------------------------------------------------------------
// cv32e40x_obi_req_stage
// Master-side OBI request stage. Takes transactions from fetch/LSU, issues
// them on the OBI A-channel, keeps req/payload stable until granted, limits
// the number of granted-but-unanswered transactions and forwards responses.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   trans_valid_i/ready_o/payload_i   upstream request handshake
//   resp_valid_o/payload_o            response to upstream (combinational)
//   obi (master modport)              OBI bus: req/req_payload/gnt/rvalid/resp
//   outstanding_o       registered outstanding-transaction count
//   protocol_err_o      sticky flag: rvalid arrived with nothing outstanding
// ---------------------------------------------------------------------------
module cv32e40x_obi_req_stage #(
  parameter  int REQ_W           = 32,
  parameter  int RESP_W          = 33,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trans_valid_i,
  output logic                      trans_ready_o,
  input  logic [REQ_W-1:0]          trans_payload_i,
  output logic                      resp_valid_o,
  output logic [RESP_W-1:0]         resp_payload_o,
  cv32e40x_obi_req_stage_if.master  obi,
  output logic [CNT_W-1:0]          outstanding_o,
  output logic                      protocol_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REQ_W-1:0]  payload_q, payload_d;
  logic              err_q, err_d;

  logic              full;
  logic              req;
  logic              ready;
  logic [REQ_W-1:0]  req_payload;
  logic              accept;
  logic              issue;
  logic              retire;

  assign full   = (cnt_q == CNT_MAX);
  assign accept = trans_valid_i & ready;
  assign issue  = req & obi.gnt;
  // A response with nothing outstanding is flagged, never counted down.
  assign retire = obi.rvalid & (cnt_q != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TRANSPARENT;
      cnt_q     <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    case (state_q)
      TRANSPARENT: begin
        // An ungranted accept is captured so upstream may move on while the
        // bus still sees the original payload.
        if (accept && !obi.gnt) begin
          payload_d = trans_payload_i;
          state_d   = REGISTERED;
        end
      end
      REGISTERED: begin
        // Return to pass-through one cycle after the grant; the grant cycle
        // itself never accepts a new transaction.
        if (obi.gnt) begin
          state_d = TRANSPARENT;
        end
      end
      default: state_d = TRANSPARENT;
    endcase
  end

  // Output logic
  always_comb begin
    req         = 1'b0;
    ready       = 1'b0;
    req_payload = trans_payload_i;
    case (state_q)
      TRANSPARENT: begin
        ready       = !full;
        req         = trans_valid_i & !full;
        req_payload = trans_payload_i;
      end
      REGISTERED: begin
        req         = 1'b1;
        req_payload = payload_q;
      end
      default: begin
        req   = 1'b0;
        ready = 1'b0;
      end
    endcase
    // Keep the bus quiet for the whole reset, not just after the first edge.
    if (rst) begin
      req   = 1'b0;
      ready = 1'b0;
    end
  end

  // Outstanding counter and sticky protocol error
  always_comb begin
    cnt_d = cnt_q;
    case ({issue, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (obi.rvalid & (cnt_q == '0));
  end

  assign obi.req         = req;
  assign obi.req_payload = req_payload;
  assign trans_ready_o   = ready;
  assign resp_valid_o    = obi.rvalid;
  assign resp_payload_o  = obi.resp_payload;
  assign outstanding_o   = cnt_q;
  assign protocol_err_o  = err_q;

endmodule
